// File: rtl/spi_rd_pkg.sv
// Shared definitions for the SPI register-readback master.
package spi_rd_pkg;

    // Transaction phases of the read master
    typedef enum logic [1:0] {
        GUARD_WAIT,
        IDLE,
        SHIFT,
        HOLD
    } state_t;

    // Width of the register address sent ahead of every read
    localparam int ADR_W = 8;

    // Level an unaddressed slave leaves on miso
    localparam logic MISO_IDLE = 1'b1;

endpackage

// File: rtl/spi_clk_phase.sv
// Half-period timer for the SPI clock. While run is high it alternates a low
// and a high phase of CLK_DIV cycles each, starting with the low phase.
// rise_tick marks the last cycle of a low phase (sclk rises on the next edge),
// fall_tick marks the last cycle of a high phase (sclk falls on the next edge).
module spi_clk_phase #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;
    logic          high_phase;
    logic          at_last;

    assign at_last   = (cnt == LAST);
    assign rise_tick = run && !high_phase && at_last;
    assign fall_tick = run &&  high_phase && at_last;

    // Count cycles within a half period; parked at the start of a low phase when idle
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            cnt        <= '0;
            high_phase <= 1'b0;
        end else if (at_last) begin
            cnt        <= '0;
            high_phase <= !high_phase;
        end else begin
            cnt        <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_rd_master.sv
// SPI read master: sends an 8-bit register address MSB-first, then clocks in
// an NBIT-bit word MSB-first and presents it on data_out with a done pulse.
// Every output is a register; the output-decode process only computes the
// value each register takes on the next edge.
module spi_rd_master
    import spi_rd_pkg::*;
#(
    parameter int NBIT    = 8,
    parameter int CLK_DIV = 4,
    parameter int GUARD   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ADR_W-1:0] adr,
    output logic             busy,
    output logic             done,
    output logic [NBIT-1:0]  data_out,
    output logic             sclk,
    output logic             mosi,
    input  logic             miso,
    output logic             cs
);

    localparam int BW = $clog2(ADR_W + NBIT + 1);
    localparam int GW = (GUARD > 0) ? $clog2(GUARD + 1) : 1;
    localparam logic [BW-1:0] LAST_BIT   = BW'(ADR_W + NBIT - 1);
    localparam logic [BW-1:0] FIRST_DATA = BW'(ADR_W);
    localparam logic [GW-1:0] GUARD_END  = GW'(GUARD);

    state_t state;
    state_t next_state;

    logic             rise_tick;
    logic             fall_tick;
    logic             run;
    logic             last_bit;
    logic             guard_over;
    logic             accept;
    logic [GW-1:0]    guard_cnt;
    logic [BW-1:0]    bit_cnt;
    logic [ADR_W-1:0] tx_sr;
    logic [NBIT-1:0]  rx_sr;

    logic cs_nxt;
    logic sclk_nxt;
    logic mosi_nxt;
    logic busy_nxt;
    logic done_nxt;

    // The HOLD phase reuses the low-phase timing, so the timer runs there too
    assign run        = (state == SHIFT) || (state == HOLD);
    assign last_bit   = (bit_cnt == LAST_BIT);
    assign guard_over = (guard_cnt == GUARD_END);
    assign accept     = (state == IDLE) && start;

    spi_clk_phase #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_phase (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .rise_tick(rise_tick),
        .fall_tick(fall_tick)
    );

    // State register; reset always lands in the guard interval
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= GUARD_WAIT;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode
    always_comb begin
        next_state = state;
        case (state)
            GUARD_WAIT: if (guard_over) next_state = IDLE;
            IDLE:       if (start) next_state = SHIFT;
            SHIFT:      if (fall_tick && last_bit) next_state = HOLD;
            HOLD:       if (rise_tick) next_state = GUARD_WAIT;
            default:    next_state = GUARD_WAIT;
        endcase
    end

    // Output decode: next values of the registered SPI pins and handshake
    always_comb begin
        cs_nxt   = cs;
        sclk_nxt = sclk;
        mosi_nxt = mosi;
        busy_nxt = busy;
        done_nxt = 1'b0;
        case (state)
            GUARD_WAIT: begin
                cs_nxt   = 1'b1;
                sclk_nxt = 1'b0;
                mosi_nxt = 1'b0;
                busy_nxt = 1'b0;
            end
            IDLE: begin
                if (start) begin
                    cs_nxt   = 1'b0;
                    sclk_nxt = 1'b0;
                    busy_nxt = 1'b1;
                    mosi_nxt = adr[ADR_W-1];
                end
            end
            SHIFT: begin
                if (rise_tick) begin
                    sclk_nxt = 1'b1;
                end
                if (fall_tick) begin
                    sclk_nxt = 1'b0;
                    mosi_nxt = tx_sr[ADR_W-2];
                end
            end
            HOLD: begin
                if (rise_tick) begin
                    cs_nxt   = 1'b1;
                    busy_nxt = 1'b0;
                    done_nxt = 1'b1;
                end
            end
            default: begin
                cs_nxt   = 1'b1;
                sclk_nxt = 1'b0;
                mosi_nxt = 1'b0;
                busy_nxt = 1'b0;
            end
        endcase
    end

    // Output registers and datapath; the transmit register shifts in zeros so
    // mosi falls to 0 by itself once the address byte is out
    always_ff @(posedge clk) begin
        if (rst) begin
            cs        <= 1'b1;
            sclk      <= 1'b0;
            mosi      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            data_out  <= '0;
            guard_cnt <= '0;
            bit_cnt   <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
        end else begin
            cs   <= cs_nxt;
            sclk <= sclk_nxt;
            mosi <= mosi_nxt;
            busy <= busy_nxt;
            done <= done_nxt;

            if (state == GUARD_WAIT) begin
                guard_cnt <= guard_cnt + 1'b1;
            end else begin
                guard_cnt <= '0;
            end

            if (accept) begin
                tx_sr   <= adr;
                bit_cnt <= '0;
            end else if (state == SHIFT && fall_tick) begin
                tx_sr   <= {tx_sr[ADR_W-2:0], 1'b0};
                bit_cnt <= bit_cnt + 1'b1;
            end

            if (state == SHIFT && rise_tick && bit_cnt >= FIRST_DATA) begin
                rx_sr <= {rx_sr[NBIT-2:0], miso};
            end

            if (state == HOLD && rise_tick) begin
                data_out <= rx_sr;
            end
        end
    end

endmodule

// File: tb/tb_spi_rd_master.sv
// Bench for spi_rd_master: a default instance and a NBIT=16 / CLK_DIV=2
// instance, each with a behavioural address-matched slave and a pin monitor.
module tb_spi_rd_master;
    import spi_rd_pkg::*;

    localparam int GUARD = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        start [2];
    logic [7:0]  adr   [2];
    logic        busy  [2];
    logic        done  [2];
    logic        sclk  [2];
    logic        mosi  [2];
    logic        cs    [2];
    logic [15:0] dout  [2];

    logic [7:0]  slv_adr  [2];
    logic [15:0] slv_word [2];

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;

    int          csfall_cnt [2] = '{0, 0};
    int          csfall_cyc [2] = '{0, 0};
    int          done_cnt   [2] = '{0, 0};
    int          done_cyc   [2] = '{0, 0};
    int          rise_cnt   [2] = '{0, 0};
    int          hp_bad     [2] = '{0, 0};
    int          mosi_bad   [2] = '{0, 0};
    int          ovl_bad    [2] = '{0, 0};
    logic [15:0] done_data  [2] = '{16'h0, 16'h0};
    logic [7:0]  rx_adr     [2] = '{8'h0, 8'h0};

    // Free-running clock and cycle counter
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : gen_inst
        localparam int NB = (g == 0) ? 8 : 16;
        localparam int H  = (g == 0) ? 4 : 2;

        logic [NB-1:0] dout_w;
        logic          miso_r    = MISO_IDLE;
        logic          prev_sclk = 1'b0;
        logic          prev_cs   = 1'b1;
        logic          prev_mosi = 1'b0;
        int            run_len   = 0;
        int            slv_rises = 0;
        logic [7:0]    slv_sr    = 8'h00;

        spi_rd_master #(
            .NBIT   (NB),
            .CLK_DIV(H),
            .GUARD  (GUARD)
        ) dut (
            .clk     (clk),
            .rst     (rst),
            .start   (start[g]),
            .adr     (adr[g]),
            .busy    (busy[g]),
            .done    (done[g]),
            .data_out(dout_w),
            .sclk    (sclk[g]),
            .mosi    (mosi[g]),
            .miso    (miso_r),
            .cs      (cs[g])
        );

        assign dout[g] = 16'(dout_w);

        // Slave: captures the address on sclk rises, drives data after sclk falls.
        // Monitor: half-period lengths, mosi stability, done/busy overlap.
        always @(negedge clk) begin
            prev_sclk <= sclk[g];
            prev_cs   <= cs[g];
            prev_mosi <= mosi[g];
            if (busy[g] && done[g]) ovl_bad[g] <= ovl_bad[g] + 1;
            if ((mosi[g] != prev_mosi && sclk[g]) || (cs[g] && mosi[g])) mosi_bad[g] <= mosi_bad[g] + 1;
            if (done[g]) begin
                done_cnt[g]  <= done_cnt[g] + 1;
                done_cyc[g]  <= cyc;
                done_data[g] <= dout[g];
            end
            if (!cs[g]) begin
                if (prev_cs) begin
                    csfall_cnt[g] <= csfall_cnt[g] + 1;
                    csfall_cyc[g] <= cyc;
                    rise_cnt[g]   <= 0;
                    run_len       <= 1;
                    slv_rises     <= 0;
                    slv_sr        <= 8'h00;
                end else if (sclk[g] == prev_sclk) begin
                    run_len <= run_len + 1;
                end else begin
                    if (run_len != H) hp_bad[g] <= hp_bad[g] + 1;
                    run_len <= 1;
                    if (sclk[g]) begin
                        rise_cnt[g] <= rise_cnt[g] + 1;
                        if (slv_rises < 8) slv_sr <= {slv_sr[6:0], mosi[g]};
                        slv_rises <= slv_rises + 1;
                    end else if (slv_rises >= 8 && slv_rises - 8 < NB) begin
                        miso_r <= (slv_sr == slv_adr[g]) ? slv_word[g][NB - 1 - (slv_rises - 8)] : MISO_IDLE;
                    end
                end
            end else begin
                miso_r <= MISO_IDLE;
                if (!prev_cs) begin
                    if (run_len != H) hp_bad[g] <= hp_bad[g] + 1;
                    rx_adr[g] <= slv_sr;
                end
            end
        end
    end

    function automatic int nb_of(input int g);
        return (g == 0) ? 8 : 16;
    endfunction

    function automatic int h_of(input int g);
        return (g == 0) ? 4 : 2;
    endfunction

    // Reference: a matching slave returns its word, anything else reads all ones
    function automatic logic [15:0] exp_word(input int g, input logic [7:0] a);
        if (a == slv_adr[g]) return slv_word[g];
        return 16'((32'd1 << nb_of(g)) - 1);
    endfunction

    // Cycles from the first cs-low cycle to the done cycle
    function automatic int exp_latency(input int g);
        return 2 * h_of(g) * (8 + nb_of(g)) + h_of(g);
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int g, input logic [7:0] a);
        start[g] = 1'b1;
        adr[g]   = a;
        tick();
        start[g] = 1'b0;
    endtask

    task automatic read_and_check(input int g, input logic [7:0] a, input string tag, input bit pre_wait);
        int dc0, hp0, mb0, ov0, s;
        if (pre_wait) repeat (GUARD + 4) tick();
        dc0 = done_cnt[g];
        hp0 = hp_bad[g];
        mb0 = mosi_bad[g];
        ov0 = ovl_bad[g];
        s   = cyc;
        applyStimulus(g, a);
        for (int i = 0; i < 3000 && done_cnt[g] == dc0; i++) tick();
        checkOutput({tag, "_done_count"}, done_cnt[g] - dc0, 1);
        checkOutput({tag, "_cs_latency"}, csfall_cyc[g] - s, 1);
        checkOutput({tag, "_done_latency"}, done_cyc[g] - csfall_cyc[g], exp_latency(g));
        checkOutput({tag, "_data"}, done_data[g], exp_word(g, a));
        checkOutput({tag, "_sclk_rises"}, rise_cnt[g], 8 + nb_of(g));
        checkOutput({tag, "_mosi_addr"}, rx_adr[g], a);
        checkOutput({tag, "_half_period"}, hp_bad[g] - hp0, 0);
        checkOutput({tag, "_mosi_stable"}, mosi_bad[g] - mb0, 0);
        checkOutput({tag, "_done_busy"}, ovl_bad[g] - ov0, 0);
        checkOutput({tag, "_busy_low"}, busy[g], 0);
    endtask

    // Watchdog so a stuck design still ends the run
    initial begin
        #600000;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int dc0, cf0, d1;
        logic [7:0] a;

        start    = '{1'b0, 1'b0};
        adr      = '{8'h00, 8'h00};
        slv_adr  = '{8'h01, 8'h01};
        slv_word = '{16'h00A5, 16'h8001};
        rst      = 1'b1;
        repeat (3) tick();
        for (int g = 0; g < 2; g++) begin
            checkOutput("rst_cs", cs[g], 1);
            checkOutput("rst_sclk", sclk[g], 0);
            checkOutput("rst_mosi", mosi[g], 0);
            checkOutput("rst_busy", busy[g], 0);
            checkOutput("rst_done", done[g], 0);
            checkOutput("rst_data", dout[g], 0);
        end
        rst = 1'b0;

        $display("[TB] default instance: matched and unmatched reads");
        read_and_check(0, 8'h01, "rd_match", 1);
        read_and_check(0, 8'h02, "rd_nomatch", 1);

        for (int i = 0; i < 6; i++) begin
            slv_adr[0]  = 8'($urandom);
            slv_word[0] = 16'($urandom_range(0, 255));
            a = ($urandom_range(0, 1) == 1) ? slv_adr[0] : 8'($urandom);
            read_and_check(0, a, "rand8", 1);
        end

        $display("[TB] start pulses while busy and during guard");
        repeat (GUARD + 4) tick();
        dc0 = done_cnt[0];
        cf0 = csfall_cnt[0];
        applyStimulus(0, slv_adr[0]);
        repeat (50) tick();
        applyStimulus(0, 8'h55);
        for (int i = 0; i < 3000 && done_cnt[0] == dc0; i++) tick();
        repeat (3) tick();
        applyStimulus(0, 8'h55);
        repeat (300) tick();
        checkOutput("ignore_done_count", done_cnt[0] - dc0, 1);
        checkOutput("ignore_cs_falls", csfall_cnt[0] - cf0, 1);

        $display("[TB] start held high back-to-back");
        slv_adr[0]  = 8'h5A;
        slv_word[0] = 16'($urandom_range(0, 255));
        dc0 = done_cnt[0];
        cf0 = csfall_cnt[0];
        start[0] = 1'b1;
        adr[0]   = 8'h5A;
        for (int i = 0; i < 3000 && done_cnt[0] == dc0; i++) tick();
        checkOutput("b2b_first_done", done_cnt[0] - dc0, 1);
        d1 = done_cyc[0];
        for (int i = 0; i < 3000 && csfall_cnt[0] < cf0 + 2; i++) tick();
        checkOutput("b2b_gap", csfall_cyc[0] - d1, GUARD + 2);
        start[0] = 1'b0;
        for (int i = 0; i < 3000 && done_cnt[0] < dc0 + 2; i++) tick();
        checkOutput("b2b_second_data", done_data[0], exp_word(0, 8'h5A));

        $display("[TB] wide instance");
        read_and_check(1, 8'h01, "w16_match", 1);
        for (int i = 0; i < 2; i++) begin
            slv_adr[1]  = 8'($urandom);
            slv_word[1] = 16'($urandom);
            a = (i == 0) ? slv_adr[1] : slv_adr[1] ^ 8'h80;
            read_and_check(1, a, "rand16", 1);
        end

        $display("[TB] reset in the middle of a read");
        slv_adr[0]  = 8'h01;
        slv_word[0] = 16'h00A5;
        read_and_check(0, 8'h01, "pre_rst", 1);
        repeat (GUARD + 4) tick();
        dc0 = done_cnt[0];
        applyStimulus(0, 8'h01);
        repeat (39) tick();
        rst = 1'b1;
        tick();
        checkOutput("abort_cs", cs[0], 1);
        checkOutput("abort_sclk", sclk[0], 0);
        checkOutput("abort_mosi", mosi[0], 0);
        checkOutput("abort_busy", busy[0], 0);
        checkOutput("abort_done", done[0], 0);
        checkOutput("abort_data", dout[0], 0);
        rst = 1'b0;
        repeat (GUARD + 1) tick();
        checkOutput("abort_no_done", done_cnt[0] - dc0, 0);
        slv_adr[0]  = 8'h3C;
        slv_word[0] = 16'($urandom_range(0, 255));
        read_and_check(0, 8'h3C, "post_rst", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
